pulse_indicator: RTL
====================

Name: pulse_indicator

Overview:
- Human-facing output conditioner, the output-side counterpart of the switch debouncer.
- Accepts single-cycle event ticks from internal logic (FIFO write/read strobes, debounced button ticks) and turns each one into a visible LED pulse.
- Every pulse has a fixed on-time followed by a guaranteed off-gap, so back-to-back events stay distinguishable.
- Events that arrive while a pulse is in progress are queued in a saturating pending counter. An overflow flag records any lost events.

Parameters:
- CNT_WIDTH, 26, width of the on/off timing counter.
- ON_CYCLES, 26'd25_000_000, number of clk_i cycles led_o is held high per event (legal range 1..2^CNT_WIDTH-1).
- OFF_CYCLES, 26'd12_500_000, number of clk_i cycles led_o is held low after each pulse (legal range 1..2^CNT_WIDTH-1).
- PEND_WIDTH, 4, width of the pending-event counter; it saturates at 2^PEND_WIDTH-1.

Ports:
- clk_i  input  1  system clock; one clock domain only.
- rst_i  input  1  reset, synchronous, active-high.
- tick_i  input  1  event strobe; each cycle it is high counts as one event.
- clear_i  input  1  synchronous soft clear; higher priority than tick_i.
- led_o  output  1  visible pulse output.
- busy_o  output  1  high whenever the FSM is not in IDLE.
- pending_o  output  PEND_WIDTH  number of queued events not yet started.
- overflow_o  output  1  sticky flag; set when an event is dropped.
- done_tick_o  output  1  one-cycle strobe in the last gap cycle of each pulse.

Behaviour:
- Reset (rst_i high at a clk_i edge): FSM goes to IDLE; timing counter, pending and overflow clear to 0. All outputs are 0 in the cycle after reset.
- FSM states:
  - IDLE: led_o=0.
  - ON: led_o=1.
  - GAP: led_o=0.
  - led_o and busy_o decode directly from the registered state, with no combinational path from tick_i.
- start condition = (pending != 0) || tick_i.
- IDLE: if start, go to ON at the next edge and clear the timing counter. Latency: tick_i sampled at edge E gives led_o=1 from edge E onward.
- ON: the counter runs 0..ON_CYCLES-1. At ON_CYCLES-1 the FSM goes to GAP and the counter clears, so led_o is high for exactly ON_CYCLES cycles.
- GAP: the counter runs 0..OFF_CYCLES-1.
  - done_tick_o = (state==GAP && cnt==OFF_CYCLES-1), which is combinational from registered state.
  - At the end of GAP: if start, go to ON (no IDLE cycle in between); else go to IDLE.
- Pending accounting, evaluated every cycle:
  - consume = the FSM is taking the IDLE->ON or GAP->ON transition this cycle.
  - tick_i && consume: pending unchanged (the arriving tick is the one served).
  - !tick_i && consume: pending - 1.
  - tick_i && !consume: pending + 1 if pending < max; if pending == max, pending holds and overflow_o sets.
- overflow_o is sticky and is cleared only by rst_i or clear_i.
- clear_i: next state is IDLE; counter, pending and overflow go to 0.
  - A tick_i arriving in the same cycle as clear_i is discarded.
  - done_tick_o is suppressed in a clear_i cycle.
  - Asserting clear_i mid-ON drops led_o the cycle after clear_i.
- rst_i takes priority over clear_i.
- pending_o is the registered counter.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, PEND_WIDTH=2):
1. Hold rst_i 2 cycles with tick_i=1 -> after release all outputs are 0, and pending_o=0 until the first sampled tick.
2. Single tick at edge E0 -> led_o=1 over edges E0..E0+3; led_o=0 over E0+4..E0+6; done_tick_o=1 only in the cycle ending at E0+7; busy_o=0 from E0+7; pending_o stays 0.
3. Three ticks on consecutive edges -> three led pulses of 4 high / 3 low each, with no IDLE between them; pending_o steps 1, 2, then decrements at each GAP->ON; done_tick_o count = 3.
4. Five consecutive ticks starting from IDLE -> first starts ON, next three saturate pending_o=3, fifth sets overflow_o=1; exactly 4 pulses follow; overflow_o stays 1 afterward.
5. Saturated pending (3) with tick_i high in the last GAP cycle -> next pulse starts, pending_o stays 3, overflow_o not set.
6. clear_i during ON cycle 2 with tick_i high the same cycle -> next cycle led_o=0, busy_o=0, pending_o=0, overflow_o=0, no done_tick_o, and no new pulse.

Source files
------------

// File: rtl/pulse_indicator_if.sv
// Event-strobe in / LED-status out bundle for pulse_indicator.
// The master drives the event strobes; the slave (the indicator) drives the status outputs.
interface pulse_indicator_if #(
  parameter int unsigned PEND_WIDTH = 4
) ();
  logic                  tick_i;
  logic                  clear_i;
  logic                  led_o;
  logic                  busy_o;
  logic [PEND_WIDTH-1:0] pending_o;
  logic                  overflow_o;
  logic                  done_tick_o;

  modport master (
    output tick_i,
    output clear_i,
    input  led_o,
    input  busy_o,
    input  pending_o,
    input  overflow_o,
    input  done_tick_o
  );

  modport slave (
    input  tick_i,
    input  clear_i,
    output led_o,
    output busy_o,
    output pending_o,
    output overflow_o,
    output done_tick_o
  );
endinterface

// File: rtl/pulse_indicator.sv
// Stretches single-cycle event ticks into fixed on-time LED pulses separated by a
// guaranteed off-gap. Ticks that arrive mid-pulse queue in a saturating counter.
module pulse_indicator #(
  parameter int unsigned           CNT_WIDTH  = 26,
  parameter logic [CNT_WIDTH-1:0]  ON_CYCLES  = 26'd25_000_000,
  parameter logic [CNT_WIDTH-1:0]  OFF_CYCLES = 26'd12_500_000,
  parameter int unsigned           PEND_WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pulse_indicator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

  localparam logic [CNT_WIDTH-1:0]  CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  OnLast  = ON_CYCLES - CntOne;
  localparam logic [CNT_WIDTH-1:0]  OffLast = OFF_CYCLES - CntOne;
  localparam logic [PEND_WIDTH-1:0] PendOne = {{(PEND_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PEND_WIDTH-1:0] PendMax = {PEND_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;

  logic start, on_end, gap_end, consume;

  assign start   = (pend_q != '0) || bus.tick_i;
  assign on_end  = (state_q == StOn) && (cnt_q == OnLast);
  assign gap_end = (state_q == StGap) && (cnt_q == OffLast);
  // A pulse is launched from IDLE or straight out of the final gap cycle.
  assign consume = !bus.clear_i && start && ((state_q == StIdle) || gap_end);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    if (bus.clear_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (start) state_d = StOn;
        end
        StOn: begin
          if (on_end) begin
            state_d = StGap;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StGap: begin
          if (gap_end) begin
            state_d = start ? StOn : StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase

      if (consume && !bus.tick_i) begin
        pend_d = pend_q - PendOne;
      end else if (!consume && bus.tick_i) begin
        if (pend_q == PendMax) ovf_d = 1'b1;
        else                   pend_d = pend_q + PendOne;
      end
    end
  end

  always_comb begin
    bus.led_o       = (state_q == StOn);
    bus.busy_o      = (state_q != StIdle);
    bus.pending_o   = pend_q;
    bus.overflow_o  = ovf_q;
    bus.done_tick_o = gap_end && !bus.clear_i;
  end

endmodule
